// File: rtl/pipe_isa_pkg.sv
// Shared ISA definitions for the issue controller: opcodes, field positions,
// FSM states, the issued-slot record and the decode helper.
package pipe_isa_pkg;

    localparam int OP_HI   = 47;
    localparam int OP_LO   = 44;
    localparam int ALU_HI  = 43;
    localparam int ALU_LO  = 40;
    localparam int RD_HI   = 39;
    localparam int RD_LO   = 35;
    localparam int RS1_HI  = 34;
    localparam int RS1_LO  = 30;
    localparam int RS2_HI  = 29;
    localparam int RS2_LO  = 25;
    localparam int ADDR_HI = 24;
    localparam int ADDR_LO = 17;
    localparam int IMM_HI  = 16;
    localparam int IMM_LO  = 1;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic [3:0]  alu_sel;
        logic [7:0]  mem_addr;
        logic        mem_we;
        logic        mem_re;
        logic [15:0] mem_wdata;
        logic        wb_sel;
    } issue_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

    localparam issue_t BUBBLE = '0;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_ALU) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_HALT);
    endfunction

    // Bit 0 of the instruction carries no meaning, so it is never passed in.
    function automatic issue_t decode(input logic [47:1] w);
        issue_t d;
        d = BUBBLE;
        case (w[OP_HI:OP_LO])
            OP_ALU: begin
                d.rs1     = w[RS1_HI:RS1_LO];
                d.rs2     = w[RS2_HI:RS2_LO];
                d.rd      = w[RD_HI:RD_LO];
                d.alu_sel = w[ALU_HI:ALU_LO];
                d.reg_we  = 1'b1;
            end
            OP_LOAD: begin
                d.rs1      = w[RS1_HI:RS1_LO];
                d.rs2      = w[RS2_HI:RS2_LO];
                d.rd       = w[RD_HI:RD_LO];
                d.mem_addr = w[ADDR_HI:ADDR_LO];
                d.mem_re   = 1'b1;
                d.reg_we   = 1'b1;
                d.wb_sel   = 1'b1;
            end
            OP_STORE: begin
                d.rs1       = w[RS1_HI:RS1_LO];
                d.rs2       = w[RS2_HI:RS2_LO];
                d.mem_addr  = w[ADDR_HI:ADDR_LO];
                d.mem_we    = 1'b1;
                d.mem_wdata = w[IMM_HI:IMM_LO];
            end
            default: d = BUBBLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pipe_issue_ctrl_raw_scoreboard.sv
// RAW hazard scoreboard: a shift register of recently issued writes compared
// against the source registers of the instruction being fetched.
module raw_scoreboard
    import pipe_isa_pkg::*;
#(
    parameter int HAZ_DEPTH = 3
) (
    input  logic       phi1_clk,
    input  logic       main_rst,
    input  logic       shift_en,
    input  logic       clear,
    input  logic       wr_valid,
    input  logic [4:0] wr_rd,
    input  logic       check_en,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       hazard
);

    sb_entry_t sb_q [HAZ_DEPTH];

    always_ff @(posedge phi1_clk or posedge main_rst) begin
        if (main_rst) begin
            for (int i = 0; i < HAZ_DEPTH; i++) sb_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < HAZ_DEPTH; i++) sb_q[i] <= '0;
        end else if (shift_en) begin
            sb_q[0] <= {wr_valid, wr_rd};
            for (int i = 1; i < HAZ_DEPTH; i++) sb_q[i] <= sb_q[i-1];
        end
    end

    // Full 5-bit compare; r0 is an ordinary register here.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (check_en && sb_q[i].valid && ((sb_q[i].rd == rs1) || (sb_q[i].rd == rs2)))
                hazard = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Instruction sequencer: host-loaded program memory, fetch/decode, RAW stall
// insertion and registered control outputs for the 4-stage datapath.
module pipe_issue_ctrl
    import pipe_isa_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int INSTR_W    = 48,
    parameter int HAZ_DEPTH  = 3,
    localparam int AW        = $clog2(IMEM_DEPTH)
) (
    input  logic               phi1_clk,
    input  logic               main_rst,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic               start,
    output logic [4:0]         iss_rs1_addr,
    output logic [4:0]         iss_rs2_addr,
    output logic [4:0]         iss_rd_addr,
    output logic               iss_reg_write_en,
    output logic [3:0]         iss_alu_sel,
    output logic [7:0]         iss_mem_addr,
    output logic               iss_mem_write_en,
    output logic               iss_mem_read_en,
    output logic [15:0]        iss_mem_write_data,
    output logic               iss_wb_data_sel,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      pc,
    output logic [15:0]        stall_cnt,
    output logic               illegal,
    output logic [1:0]         fsm_state
);

    localparam int DW = $clog2(HAZ_DEPTH + 1);

    logic [INSTR_W-1:0] imem [IMEM_DEPTH];

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [15:0]        stall_q, stall_d;
    logic               illegal_q, illegal_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               first_q, first_d;
    logic [INSTR_W-1:1] first_word_q, first_word_d;
    issue_t             iss_q, iss_d;

    logic [INSTR_W-1:1] fetch_word;
    logic [3:0]         op;
    logic               hazard;
    logic               sb_shift;
    logic               sb_clear;
    logic               prog_ok;

    assign prog_ok = (state_q == ST_IDLE) || (state_q == ST_DONE);

    always_ff @(posedge phi1_clk) begin
        if (prog_we && prog_ok) imem[prog_addr] <= prog_wdata;
    end

    // Word 0 is captured at the start edge, so a same-cycle write to address 0
    // only becomes visible on the next run.
    assign fetch_word = first_q ? first_word_q : imem[pc_q][INSTR_W-1:1];
    assign op         = fetch_word[OP_HI:OP_LO];

    raw_scoreboard #(.HAZ_DEPTH(HAZ_DEPTH)) u_sb (
        .phi1_clk (phi1_clk),
        .main_rst (main_rst),
        .shift_en (sb_shift),
        .clear    (sb_clear),
        .wr_valid (iss_d.reg_we),
        .wr_rd    (iss_d.rd),
        .check_en ((state_q == ST_RUN) && (op == OP_ALU)),
        .rs1      (fetch_word[RS1_HI:RS1_LO]),
        .rs2      (fetch_word[RS2_HI:RS2_LO]),
        .hazard   (hazard)
    );

    always_ff @(posedge phi1_clk or posedge main_rst) begin
        if (main_rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            stall_q      <= '0;
            illegal_q    <= 1'b0;
            drain_q      <= '0;
            first_q      <= 1'b0;
            first_word_q <= '0;
            iss_q        <= BUBBLE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stall_q      <= stall_d;
            illegal_q    <= illegal_d;
            drain_q      <= drain_d;
            first_q      <= first_d;
            first_word_q <= first_word_d;
            iss_q        <= iss_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stall_d      = stall_q;
        illegal_d    = illegal_q;
        drain_d      = drain_q;
        first_d      = first_q;
        first_word_d = first_word_q;
        iss_d        = BUBBLE;
        sb_shift     = 1'b0;
        sb_clear     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    pc_d         = '0;
                    stall_d      = '0;
                    illegal_d    = 1'b0;
                    first_d      = 1'b1;
                    first_word_d = imem[0][INSTR_W-1:1];
                    sb_clear     = 1'b1;
                end
            end
            ST_RUN: begin
                sb_shift = 1'b1;
                first_d  = 1'b0;
                if (hazard) begin
                    if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                end else if (op == OP_HALT) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(HAZ_DEPTH);
                end else begin
                    iss_d = decode(fetch_word);
                    if (!op_is_legal(op)) illegal_d = 1'b1;
                    pc_d = pc_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                sb_shift = 1'b1;
                drain_d  = drain_q - DW'(1);
                if (drain_q <= DW'(1)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign iss_rs1_addr       = iss_q.rs1;
    assign iss_rs2_addr       = iss_q.rs2;
    assign iss_rd_addr        = iss_q.rd;
    assign iss_reg_write_en   = iss_q.reg_we;
    assign iss_alu_sel        = iss_q.alu_sel;
    assign iss_mem_addr       = iss_q.mem_addr;
    assign iss_mem_write_en   = iss_q.mem_we;
    assign iss_mem_read_en    = iss_q.mem_re;
    assign iss_mem_write_data = iss_q.mem_wdata;
    assign iss_wb_data_sel    = iss_q.wb_sel;
    assign busy               = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done               = (state_q == ST_DONE);
    assign pc                 = pc_q;
    assign stall_cnt          = stall_q;
    assign illegal            = illegal_q;
    assign fsm_state          = state_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Self-checking bench for pipe_issue_ctrl: table-driven programs plus
// hand-written sequences for stall timing, mid-run reset and start/write overlap.
module tb_pipe_issue_ctrl;
    import pipe_isa_pkg::*;

    logic        phi1_clk;
    logic        main_rst;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [47:0] prog_wdata;
    logic        start;
    logic [4:0]  iss_rs1_addr, iss_rs2_addr, iss_rd_addr;
    logic        iss_reg_write_en;
    logic [3:0]  iss_alu_sel;
    logic [7:0]  iss_mem_addr;
    logic        iss_mem_write_en, iss_mem_read_en;
    logic [15:0] iss_mem_write_data;
    logic        iss_wb_data_sel;
    logic        busy, done;
    logic [5:0]  pc;
    logic [15:0] stall_cnt;
    logic        illegal;
    logic [1:0]  fsm_state;

    int checks = 0;
    int failures = 0;
    logic [46:0] exp_q[$];

    pipe_issue_ctrl dut (
        .phi1_clk(phi1_clk), .main_rst(main_rst), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata), .start(start),
        .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr),
        .iss_rd_addr(iss_rd_addr), .iss_reg_write_en(iss_reg_write_en),
        .iss_alu_sel(iss_alu_sel), .iss_mem_addr(iss_mem_addr),
        .iss_mem_write_en(iss_mem_write_en), .iss_mem_read_en(iss_mem_read_en),
        .iss_mem_write_data(iss_mem_write_data), .iss_wb_data_sel(iss_wb_data_sel),
        .busy(busy), .done(done), .pc(pc), .stall_cnt(stall_cnt),
        .illegal(illegal), .fsm_state(fsm_state)
    );

    // clock / reset
    initial phi1_clk = 1'b0;
    always #5 phi1_clk = ~phi1_clk;

    typedef struct packed {
        logic [5:0][47:0] prog;
        logic [3:0]       n_prog;
        logic [3:0][46:0] exp;
        logic [3:0]       n_exp;
        logic [15:0]      stall;
        logic             ill;
    } vec_t;

    localparam int NV = 6;
    vec_t vec [NV];

    function automatic logic [47:0] mk(input logic [3:0] op, input logic [3:0] alu,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [7:0] addr,
                                       input logic [15:0] imm);
        return {op, alu, rd, rs1, rs2, addr, imm, 1'b0};
    endfunction

    function automatic logic [46:0] ex(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd, input logic we,
                                       input logic [3:0] alu, input logic [7:0] maddr,
                                       input logic mwe, input logic mre,
                                       input logic [15:0] mwd, input logic wb);
        return {rs1, rs2, rd, we, alu, maddr, mwe, mre, mwd, wb};
    endfunction

    function automatic logic [46:0] cur_issue();
        return {iss_rs1_addr, iss_rs2_addr, iss_rd_addr, iss_reg_write_en, iss_alu_sel,
                iss_mem_addr, iss_mem_write_en, iss_mem_read_en, iss_mem_write_data,
                iss_wb_data_sel};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge phi1_clk);
        #1;
    endtask

    task automatic write_word(input logic [5:0] a, input logic [47:0] d);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", {63'd0, busy}, 64'd1);
        chk("start_illegal_clr", {63'd0, illegal}, 64'd0);
        chk("start_stall_clr", {48'd0, stall_cnt}, 64'd0);
    endtask

    // scoreboard pop: every non-bubble slot must match the next expected issue
    task automatic sample_issue();
        logic [46:0] act;
        act = cur_issue();
        if (act != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {17'd0, act}, 64'd0);
            end else begin
                chk("issue", {17'd0, act}, {17'd0, exp_q.pop_front()});
            end
        end
    endtask

    task automatic drain_to_done();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step();
            sample_issue();
            if (done) begin ok = 1'b1; break; end
        end
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_checks(input logic [15:0] exp_stall, input logic exp_ill);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, exp_stall});
        chk("illegal", {63'd0, illegal}, {63'd0, exp_ill});
        chk("done_busy", {62'd0, done, busy}, 64'd2);
        chk("done_bubble", {17'd0, cur_issue()}, 64'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] rimm;
        main_rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; start = 1'b0;
        rimm = 16'($urandom_range(0, 16'hFFFF));

        vec = '{default: '0};
        vec[0].prog[0] = mk(OP_ALU, 4'h0, 5'd3, 5'd1, 5'd2, 8'h00, 16'h0) | 48'h1;
        vec[0].prog[1] = mk(OP_HALT, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 16'h0);
        vec[0].n_prog = 2;
        vec[0].exp[0] = ex(5'd1, 5'd2, 5'd3, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
        vec[0].n_exp = 1;

        vec[1].prog[0] = mk(OP_ALU, 4'h0, 5'd3, 5'd1, 5'd2, 8'h00, 16'h0);
        vec[1].prog[1] = mk(OP_ALU, 4'h2, 5'd4, 5'd3, 5'd0, 8'h00, 16'h0);
        vec[1].prog[2] = mk(OP_HALT, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 16'h0);
        vec[1].n_prog = 3;
        vec[1].exp[0] = ex(5'd1, 5'd2, 5'd3, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
        vec[1].exp[1] = ex(5'd3, 5'd0, 5'd4, 1'b1, 4'h2, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
        vec[1].n_exp = 2; vec[1].stall = 16'd3;

        vec[2].prog[0] = mk(OP_STORE, 4'h0, 5'd9, 5'd6, 5'd0, 8'h10, 16'hBEEF);
        vec[2].prog[1] = mk(OP_LOAD, 4'h0, 5'd5, 5'd0, 5'd0, 8'h10, 16'h1234);
        vec[2].prog[2] = mk(OP_STORE, 4'h0, 5'd0, 5'd0, 5'd0, 8'h22, rimm);
        vec[2].prog[3] = mk(OP_HALT, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 16'h0);
        vec[2].n_prog = 4;
        vec[2].exp[0] = ex(5'd6, 5'd0, 5'd0, 1'b0, 4'h0, 8'h10, 1'b1, 1'b0, 16'hBEEF, 1'b0);
        vec[2].exp[1] = ex(5'd0, 5'd0, 5'd5, 1'b1, 4'h0, 8'h10, 1'b0, 1'b1, 16'h0, 1'b1);
        vec[2].exp[2] = ex(5'd0, 5'd0, 5'd0, 1'b0, 4'h0, 8'h22, 1'b1, 1'b0, rimm, 1'b0);
        vec[2].n_exp = 3;

        vec[3].prog[0] = mk(OP_ALU, 4'h0, 5'd7, 5'd1, 5'd2, 8'h00, 16'h0);
        vec[3].prog[1] = mk(OP_NOP, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 16'h0);
        vec[3].prog[2] = mk(OP_NOP, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 16'h0);
        vec[3].prog[3] = mk(OP_NOP, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 16'h0);
        vec[3].prog[4] = mk(OP_ALU, 4'h5, 5'd9, 5'd8, 5'd7, 8'h00, 16'h0);
        vec[3].prog[5] = mk(OP_HALT, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 16'h0);
        vec[3].n_prog = 6;
        vec[3].exp[0] = ex(5'd1, 5'd2, 5'd7, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
        vec[3].exp[1] = ex(5'd8, 5'd7, 5'd9, 1'b1, 4'h5, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
        vec[3].n_exp = 2;

        vec[4].prog[0] = mk(4'h5, 4'h3, 5'd1, 5'd2, 5'd3, 8'h44, 16'h5555);
        vec[4].prog[1] = mk(OP_HALT, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 16'h0);
        vec[4].n_prog = 2; vec[4].ill = 1'b1;

        vec[5].prog[0] = mk(OP_ALU, 4'h1, 5'd0, 5'd1, 5'd1, 8'h00, 16'h0);
        vec[5].prog[1] = mk(OP_ALU, 4'h3, 5'd2, 5'd0, 5'd4, 8'h00, 16'h0);
        vec[5].prog[2] = mk(OP_HALT, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 16'h0);
        vec[5].n_prog = 3;
        vec[5].exp[0] = ex(5'd1, 5'd1, 5'd0, 1'b1, 4'h1, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
        vec[5].exp[1] = ex(5'd0, 5'd4, 5'd2, 1'b1, 4'h3, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
        vec[5].n_exp = 2; vec[5].stall = 16'd3;

        // reset state
        repeat (2) @(posedge phi1_clk);
        #1;
        chk("rst_pc", {58'd0, pc}, 64'd0);
        chk("rst_issue", {17'd0, cur_issue()}, 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst_stall", {48'd0, stall_cnt}, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        chk("rst_state", {62'd0, fsm_state}, {62'd0, ST_IDLE});
        main_rst = 1'b0;
        step();

        for (int v = 0; v < NV; v++) begin
            for (int w = 0; w < int'(vec[v].n_prog); w++) write_word(6'(w), vec[v].prog[w]);
            for (int e = 0; e < int'(vec[v].n_exp); e++) exp_q.push_back(vec[v].exp[e]);
            start_run();
            drain_to_done();
            finish_checks(vec[v].stall, vec[v].ill);
        end

        // pc holds at the consumer while the producer is in flight
        for (int w = 0; w < 3; w++) write_word(6'(w), vec[1].prog[w]);
        start_run();
        step();
        chk("hold_first_issue", {59'd0, iss_rd_addr}, 64'd3);
        chk("hold_pc_after_issue", {58'd0, pc}, 64'd1);
        for (int b = 0; b < 3; b++) begin
            step();
            chk("hold_pc", {58'd0, pc}, 64'd1);
            chk("hold_bubble", {17'd0, cur_issue()}, 64'd0);
            chk("hold_stall", {48'd0, stall_cnt}, 64'(b + 1));
        end
        step();
        chk("hold_pc_release", {58'd0, pc}, 64'd2);
        chk("hold_second_issue", {17'd0, cur_issue()}, {17'd0, vec[1].exp[1]});
        drain_to_done();
        finish_checks(16'd3, 1'b0);

        // mid-run reset at pc 4, with an ignored program write during RUN
        for (int w = 0; w < 7; w++)
            write_word(6'(w), mk(OP_ALU, 4'(w), 5'(10 + w), 5'd1, 5'd2, 8'h00, 16'h0));
        write_word(6'd7, mk(OP_HALT, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 16'h0));
        start_run();
        step();
        prog_we = 1'b1; prog_addr = 6'd2;
        prog_wdata = mk(OP_ALU, 4'hF, 5'd31, 5'd1, 5'd2, 8'h00, 16'h0);
        step();
        prog_we = 1'b0;
        step();
        step();
        chk("pre_reset_pc", {58'd0, pc}, 64'd4);
        main_rst = 1'b1;
        #1;
        chk("mid_rst_pc", {58'd0, pc}, 64'd0);
        chk("mid_rst_state", {62'd0, fsm_state}, {62'd0, ST_IDLE});
        chk("mid_rst_issue", {17'd0, cur_issue()}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        #1;
        main_rst = 1'b0;
        step();
        for (int w = 0; w < 7; w++)
            exp_q.push_back(ex(5'd1, 5'd2, 5'(10 + w), 1'b1, 4'(w), 8'h00, 1'b0, 1'b0, 16'h0, 1'b0));
        start_run();
        drain_to_done();
        finish_checks(16'd0, 1'b0);

        // write to address 0 in the start cycle: this run sees the old word 0
        for (int w = 0; w < 7; w++)
            exp_q.push_back(ex(5'd1, 5'd2, 5'(10 + w), 1'b1, 4'(w), 8'h00, 1'b0, 1'b0, 16'h0, 1'b0));
        prog_we = 1'b1; prog_addr = 6'd0;
        prog_wdata = mk(OP_ALU, 4'h9, 5'd20, 5'd1, 5'd2, 8'h00, 16'h0);
        start_run();
        prog_we = 1'b0;
        drain_to_done();
        finish_checks(16'd0, 1'b0);

        exp_q.push_back(ex(5'd1, 5'd2, 5'd20, 1'b1, 4'h9, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0));
        for (int w = 1; w < 7; w++)
            exp_q.push_back(ex(5'd1, 5'd2, 5'(10 + w), 1'b1, 4'(w), 8'h00, 1'b0, 1'b0, 16'h0, 1'b0));
        start_run();
        drain_to_done();
        finish_checks(16'd0, 1'b0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
